// File: rtl/minsoc_clk_div.sv
// minsoc_clk_div: multi-channel programmable clock divider.
// Each channel produces a registered divided clock, a matching enable pulse,
// a divisor-change acknowledge and a lock flag. Divisor changes take effect
// only on a period boundary, so no channel ever emits a runt pulse.
// Optional build macro MINSOC_CLK_DIV_LOCK_EN: with it, locked_o waits for
// LOCK_CYCLES output periods; without it, locked_o only reflects "not stopped".

module minsoc_clk_div_ch #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int LOCK_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_load_i,
  output logic             div_ack_o,
  output logic             clk_o,
  output logic             ce_o,
  output logic             locked_o
);
  localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DDIV = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] r_div_q, r_cnt, r_pend;
  logic             r_pend_v, r_app;
  logic             w_run, w_wrap, w_apply;
  logic [DIV_W-1:0] w_new;
  logic [DIV_W:0]   w_half;

  // Divisors 0/1 never count; every other divisor wraps at div_q-1.
  assign w_run  = r_div_q > ONE;
  assign w_wrap = w_run && (r_cnt == r_div_q - ONE);
  // Stopped/div-1 channels have no period to finish, so a load applies at once.
  // A load on the wrap cycle wins over an older pending value.
  assign w_apply = w_run ? (w_wrap && (div_load_i || r_pend_v)) : div_load_i;
  assign w_new   = div_load_i ? div_i : r_pend;
  // High phase length ceil(div/2): odd divisors get the extra cycle high.
  assign w_half  = ((DIV_W+1)'(r_div_q) + (DIV_W+1)'(1)) >> 1;

  // Divisor, counter and pending-load bookkeeping.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_div_q  <= DDIV;
      r_cnt    <= '0;
      r_pend   <= '0;
      r_pend_v <= 1'b0;
    end else if (w_apply) begin
      r_div_q  <= w_new;
      r_cnt    <= '0;
      r_pend_v <= 1'b0;
    end else begin
      r_cnt <= (w_run && !w_wrap) ? r_cnt + ONE : '0;
      if (div_load_i) begin
        r_pend   <= div_i;
        r_pend_v <= 1'b1;
      end
    end
  end

  // Output decode of the current count; ack trails the apply edge by one
  // cycle so it lines up with the first enable of the new divisor.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_app     <= 1'b0;
      div_ack_o <= 1'b0;
      ce_o      <= 1'b0;
      clk_o     <= 1'b0;
    end else begin
      r_app     <= w_apply;
      div_ack_o <= r_app;
      ce_o      <= (r_div_q == ONE) || (w_run && r_cnt == '0);
      clk_o     <= w_run && ((DIV_W+1)'(r_cnt) < w_half);
    end
  end

`ifdef MINSOC_CLK_DIV_LOCK_EN
  localparam logic [7:0] LK_MAX = 8'(LOCK_CYCLES);
  logic [7:0] r_lk;

  // Count enable pulses of the current divisor; the pulse in the cycle right
  // after an apply still belongs to the old divisor and is skipped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                              r_lk <= '0;
    else if (w_apply)                          r_lk <= '0;
    else if (ce_o && !r_app && r_lk != LK_MAX) r_lk <= r_lk + 8'd1;
  end

  assign locked_o = (r_lk == LK_MAX) && (r_div_q != '0);
`else
  logic r_locked;

  // Without a lock counter the channel counts as locked whenever it runs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_locked <= 1'b0;
    else          r_locked <= (r_div_q != '0) && !w_apply;
  end

  assign locked_o = r_locked;
`endif
endmodule

module minsoc_clk_div #(
  parameter int CHANNELS    = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [CHANNELS*DIV_W-1:0] div_i,
  input  logic [CHANNELS-1:0]       div_load_i,
  output logic [CHANNELS-1:0]       div_ack_o,
  output logic [CHANNELS-1:0]       clk_o,
  output logic [CHANNELS-1:0]       ce_o,
  output logic [CHANNELS-1:0]       locked_o
);
  if (CHANNELS < 1 || CHANNELS > 8 || LOCK_CYCLES < 1 || LOCK_CYCLES > 255) begin : g_bad_param
    $error("minsoc_clk_div: CHANNELS must be 1..8 and LOCK_CYCLES 1..255");
  end

  // One fully independent divider per channel.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    minsoc_clk_div_ch #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV),
      .LOCK_CYCLES(LOCK_CYCLES)
    ) u_ch (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .div_i     (div_i[g*DIV_W +: DIV_W]),
      .div_load_i(div_load_i[g]),
      .div_ack_o (div_ack_o[g]),
      .clk_o     (clk_o[g]),
      .ce_o      (ce_o[g]),
      .locked_o  (locked_o[g])
    );
  end
endmodule

// File: doc/minsoc_clk_div.md
# minsoc_clk_div

Portable, vendor-neutral multi-channel programmable clock divider. Successor to the fixed-divisor DCM wrapper. Derives up to CHANNELS divided clocks and matching clock-enable pulses from one system clock. Each channel's divisor can be changed at run time; the change is applied only at a period boundary, so no runt pulses appear on any output. Sits beside the SoC clock input; it feeds peripheral clock-enables and low-speed clock outputs on targets without DCM/DLL primitives, or where runtime divisor changes are needed.

## Interface
Parameters:
- CHANNELS, 2, number of independent divider channels (1..8)
- DIV_W, 8, divisor width in bits
- DEFAULT_DIV, 2, divisor loaded into every channel at reset
- LOCK_CYCLES, 16, number of output periods before `locked_o` asserts (1..255)

Ports:
- clk_i  in  1  system clock; all logic on its rising edge
- rst_n_i  in  1  reset, asynchronous and active-low
- div_i  in  CHANNELS*DIV_W  requested divisors; channel n uses bits [n*DIV_W +: DIV_W]
- div_load_i  in  CHANNELS  per-channel load strobe, one cycle wide
- div_ack_o  out  CHANNELS  one-cycle pulse when a new divisor takes effect
- clk_o  out  CHANNELS  registered divided clock
- ce_o  out  CHANNELS  one-cycle enable pulse, coincident with each `clk_o` rising edge
- locked_o  out  CHANNELS  channel output is stable at its current divisor

## Operation
Per-channel state:
- active divisor `div_q`
- counter `cnt` (DIV_W bits)
- pending divisor `pend` with valid flag `pend_v`
- lock counter `lk` (8 bits)

Counting:
- `cnt` runs 0 .. `div_q`-1, then wraps to 0. The wrap cycle is the one where `cnt` == `div_q`-1.
- Registered outputs are decoded from the current `cnt`:
  - `ce_o` = (`cnt` == 0)
  - `clk_o` = (`cnt` < ceil(`div_q`/2))
- Odd divisors give a high phase one cycle longer than the low phase (e.g. div 3: high 2 cycles, low 1).

Special divisors:
- div 0: channel stopped. `cnt` held at 0, `clk_o`=0, `ce_o`=0, `locked_o`=0.
- div 1: `ce_o`=1 every cycle, `clk_o`=0, `cnt` held at 0.

Divisor load:
- `div_load_i[n]` captures `div_i` slice n into `pend` and sets `pend_v`.
- A second load before apply overwrites `pend`; only the last value is applied.
- Apply point:
  - the wrap cycle, if `div_q` >= 2
  - the next cycle, if `div_q` is 0 or 1
- On apply: `div_q` ← new value, `cnt` ← 0, `pend_v` cleared, `div_ack_o` pulses, `lk` cleared, `locked_o` drops.
- Load on the wrap cycle itself: `div_i` is applied at that wrap directly, bypassing `pend`. It overrides any older `pend`.

Lock:
- `lk` increments on each `ce_o` pulse and saturates at LOCK_CYCLES.
- `locked_o` = (`lk` == LOCK_CYCLES) and `div_q` != 0.

Channels are fully independent; there is no cross-channel phase alignment.

## Timing
Reset (`rst_n_i` low, asynchronous), all channels:
- `div_q`=DEFAULT_DIV, `cnt`=0, `pend_v`=0, `lk`=0
- `clk_o`=0, `ce_o`=0, `div_ack_o`=0, `locked_o`=0

After reset release:
- First `clk_i` edge: registers decode of `cnt`=0, so `ce_o`=1 and `clk_o`=1 during cycle 1.
- Period is exactly `div_q` cycles from then on.

Load and apply latency:
- Load strobe in cycle t: the new divisor's first `ce_o` comes in cycle (first apply point after t)+1.
- `div_ack_o` is high in the same cycle as that first `ce_o`.

Lock latency: `locked_o` rises in the cycle after the LOCK_CYCLES-th `ce_o` pulse following reset or apply.

Reset mid-operation: pending loads are discarded and all outputs go to their reset values immediately, with no clock required.

## Configuration
- `MINSOC_CLK_DIV_LOCK_EN` defined: lock counter as described above.
- Not defined: lock counters are removed. `locked_o` is registered (`div_q` != 0), so it is high one cycle after reset release or apply and low when stopped. `div_ack_o` is unchanged.

## Test plan
- Reset release, DEFAULT_DIV=2: `clk_o` toggles every cycle, `ce_o` pulses every 2 cycles starting in cycle 1; `locked_o` rises after the 16th pulse (with `MINSOC_CLK_DIV_LOCK_EN`).
- Channel 0 loaded with 5 mid-period while at div 4: the current 4-cycle period completes; `div_ack_o[0]` pulses with the next `ce_o`; then periods are 5 cycles with `clk_o` high 3 / low 2. Channel 1 is unaffected.
- Two loads (6, then 9) within one period at div 8: only 9 is applied; exactly one `div_ack_o` pulse.
- Load 3 asserted on the wrap cycle: 3 is applied at that wrap; the next `ce_o` follows 3 cycles later.
- Load 0, then 7 while stopped: `clk_o`/`ce_o`/`locked_o` held at 0; 7 is applied on the cycle after its load, and `ce_o` resumes the following cycle.
- `rst_n_i` pulsed low mid-period with a pending load: all outputs go to 0 immediately; after release the channel runs at DEFAULT_DIV and the pending value is never applied.
